// File: rtl/inst_mem_burst_responder_if.sv
// Avalon-MM style burst-read bus between the fetch controller's read master
// and the instruction memory responder.
interface inst_mem_burst_responder_if #(
  parameter int P_ADDR_BITS = 32,
  parameter int P_WORD_BITS = 32
);
  logic [P_ADDR_BITS-1:0] addr;
  logic                   read;
  logic [P_WORD_BITS-1:0] burstcount;
  logic                   waitrequest;
  logic [P_WORD_BITS-1:0] readdata;
  logic                   readdatavalid;

  modport master (
    output addr, read, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  addr, read, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/inst_mem_burst_responder.sv
// Burst read responder for instruction fetch: command FIFO, burst sequencer,
// and a synchronous instruction RAM with a loader write port.
module inst_mem_burst_responder #(
  parameter int P_ADDR_BITS      = 32,
  parameter int P_WORD_BITS      = 32,
  parameter int P_DEPTH_LOG2     = 8,
  parameter int P_CMD_DEPTH      = 4,
  parameter int P_CMD_DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  inst_mem_burst_responder_if.slave bus,
  input  logic                    i_flush,
  input  logic [P_DEPTH_LOG2-1:0] i_ld_addr,
  input  logic [P_WORD_BITS-1:0]  i_ld_data,
  input  logic                    i_ld_we,
  output logic                    o_busy
);
  localparam int BYTE_SHIFT = $clog2(P_WORD_BITS / 8);
  localparam int DEPTH      = 1 << P_DEPTH_LOG2;
  localparam int CNT_W      = P_CMD_DEPTH_LOG2 + 1;

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  state_t                      state_reg, state_next;
  logic [P_DEPTH_LOG2-1:0]     word_idx_reg, word_idx_next;
  logic [P_WORD_BITS-1:0]      beats_left_reg, beats_left_next;
  logic                        valid_reg;
  logic [P_WORD_BITS-1:0]      rd_data_reg;

  logic [P_CMD_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg, wr_slot;
  logic [CNT_W-1:0]            count_reg;
  logic [P_DEPTH_LOG2-1:0]     fifo_idx   [P_CMD_DEPTH];
  logic [P_WORD_BITS-1:0]      fifo_beats [P_CMD_DEPTH];
  logic [P_CMD_DEPTH-1:0]      slot_we;
  logic [P_WORD_BITS-1:0]      mem [DEPTH];

  logic fifo_full, fifo_empty, push, pop, rd_en, load;
  logic [P_DEPTH_LOG2-1:0] push_idx, head_idx;
  logic [P_WORD_BITS-1:0]  push_beats, head_beats;
  wire unused_addr_bits = &{1'b0, bus.addr};

  assign fifo_full  = (count_reg == CNT_W'(P_CMD_DEPTH));
  assign fifo_empty = (count_reg == '0);
  // Held high while in reset so nothing is accepted before the FIFO is valid.
  assign bus.waitrequest = fifo_full | ~rst;
  assign push       = bus.read & ~bus.waitrequest;
  assign push_idx   = bus.addr[BYTE_SHIFT +: P_DEPTH_LOG2];
  assign push_beats = bus.burstcount >> BYTE_SHIFT;
  // A flush restarts the FIFO at slot 0, so a same-cycle command lands there.
  assign wr_slot    = i_flush ? '0 : wr_ptr_reg;
  assign head_idx   = fifo_idx[rd_ptr_reg];
  assign head_beats = fifo_beats[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < P_CMD_DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = push && (wr_slot == P_CMD_DEPTH_LOG2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < P_CMD_DEPTH; i++) begin
      if (slot_we[i]) begin
        fifo_idx[i]   <= push_idx;
        fifo_beats[i] <= push_beats;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (i_flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= push ? P_CMD_DEPTH_LOG2'(1) : '0;
      count_reg  <= push ? CNT_W'(1) : '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + P_CMD_DEPTH_LOG2'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + P_CMD_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    state_next      = state_reg;
    word_idx_next   = word_idx_reg;
    beats_left_next = beats_left_reg;
    pop             = 1'b0;
    rd_en           = 1'b0;
    load            = 1'b0;
    case (state_reg)
      IDLE: load = ~fifo_empty;
      BURST: begin
        rd_en           = 1'b1;
        word_idx_next   = word_idx_reg + P_DEPTH_LOG2'(1);
        beats_left_next = beats_left_reg - P_WORD_BITS'(1);
        // Chain straight into the next queued burst on the last beat.
        if (beats_left_reg == P_WORD_BITS'(1)) begin
          state_next = IDLE;
          load       = ~fifo_empty;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      pop             = 1'b1;
      word_idx_next   = head_idx;
      beats_left_next = head_beats;
      state_next      = (head_beats != '0) ? BURST : IDLE;
    end
    if (i_flush) begin
      pop             = 1'b0;
      state_next      = IDLE;
      beats_left_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      word_idx_reg   <= '0;
      beats_left_reg <= '0;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_idx_reg   <= word_idx_next;
      beats_left_reg <= beats_left_next;
      valid_reg      <= rd_en & ~i_flush;
    end
  end

  always_ff @(posedge clk) begin
    if (i_ld_we) mem[i_ld_addr] <= i_ld_data;
  end

  // Read port samples the pre-write contents when the loader hits the same word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[word_idx_reg];
  end

  assign bus.readdata      = rd_data_reg;
  assign bus.readdatavalid = valid_reg;
  assign o_busy = (state_reg == BURST) | ~fifo_empty | valid_reg;
endmodule

// File: tb/tb_inst_mem_burst_responder.sv
// Directed bench for inst_mem_burst_responder: bursts, chaining, FIFO full,
// wrap, flush, loader collision, zero-length commands and mid-burst reset.
module tb_inst_mem_burst_responder;
  logic        clk;
  logic        rst;
  logic        i_flush;
  logic [7:0]  i_ld_addr;
  logic [31:0] i_ld_data;
  logic        i_ld_we;
  logic        o_busy;

  inst_mem_burst_responder_if #(.P_ADDR_BITS(32), .P_WORD_BITS(32)) bus ();

  inst_mem_burst_responder dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .i_flush  (i_flush),
    .i_ld_addr(i_ld_addr),
    .i_ld_data(i_ld_data),
    .i_ld_we  (i_ld_we),
    .o_busy   (o_busy)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic [31:0] q_data[$];
  int          q_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.readdatavalid) begin
      q_data.push_back(bus.readdata);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("vec %0d %s: 0x%0h ok", n_vec, tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ld(input logic [7:0] idx, input logic [31:0] data);
    i_ld_addr = idx;
    i_ld_data = data;
    i_ld_we   = 1'b1;
    tick(1);
    i_ld_we   = 1'b0;
  endtask

  // Presents one command until accepted; acc is the cycle of the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] bc, output int acc, output logic wr0);
    int   n;
    logic took;
    bus.addr       = a;
    bus.burstcount = bc;
    bus.read       = 1'b1;
    wr0  = bus.waitrequest;
    took = 1'b0;
    n    = 0;
    while (!took && n < 100) begin
      took = ~bus.waitrequest;
      tick(1);
      n++;
    end
    bus.read = 1'b0;
    acc = cyc;
    check("send_accept", {31'd0, took}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_idle", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 100) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int   acc, a0;
    logic wr0;
    rst = 1'b1;
    i_flush = 1'b0; i_ld_we = 1'b0; i_ld_addr = '0; i_ld_data = '0;
    bus.read = 1'b0; bus.addr = '0; bus.burstcount = '0;
    #2 rst = 1'b0;
    tick(2);
    check("rst_waitreq", {31'd0, bus.waitrequest}, 32'd1);
    check("rst_valid",   {31'd0, bus.readdatavalid}, 32'd0);
    check("rst_busy",    {31'd0, o_busy}, 32'd0);
    check("rst_rdata",   bus.readdata, 32'd0);
    rst = 1'b1;
    tick(1);
    check("rel_waitreq", {31'd0, bus.waitrequest}, 32'd0);

    for (int i = 0; i < 16; i++) ld(8'(i), 32'h100 + i);

    // Single 8-beat burst
    q_data.delete(); q_cyc.delete();
    send(32'h0, 32'd32, acc, wr0);
    wait_idle();
    check("t1_count", q_data.size(), 32'd8);
    check("t1_latency", q_cyc[0], acc + 2);
    check("t1_contig", q_cyc[7] - q_cyc[0], 32'd7);
    for (int i = 0; i < 8; i++) check($sformatf("t1_d%0d", i), q_data[i], 32'h100 + i);

    // Back-to-back bursts with no bubble
    q_data.delete(); q_cyc.delete();
    send(32'h0, 32'd16, acc, wr0);
    send(32'h10, 32'd16, acc, wr0);
    wait_idle();
    check("t2_count", q_data.size(), 32'd8);
    check("t2_contig", q_cyc[7] - q_cyc[0], 32'd7);
    for (int i = 0; i < 8; i++) check($sformatf("t2_d%0d", i), q_data[i], 32'h100 + i);

    // Fill the command FIFO behind a 16-beat burst
    q_data.delete(); q_cyc.delete();
    send(32'h0, 32'd64, a0, wr0);
    for (int i = 0; i < 4; i++) send(32'(i * 4), 32'd4, acc, wr0);
    send(32'h10, 32'd4, acc, wr0);
    check("t3_full_wait", {31'd0, wr0}, 32'd1);
    check("t3_late_acc", acc, a0 + 18);
    wait_idle();
    check("t3_count", q_data.size(), 32'd21);
    check("t3_contig", q_cyc[20] - q_cyc[0], 32'd20);
    check("t3_last", q_data[20], 32'h104);

    // Zero-beat command, then unaligned address / burstcount
    q_data.delete(); q_cyc.delete();
    send(32'h0, 32'd0, acc, wr0);
    wait_idle();
    tick(3);
    check("t8_zero_beats", q_data.size(), 32'd0);
    send(32'hD, 32'd7, acc, wr0);
    wait_idle();
    check("t8_count", q_data.size(), 32'd1);
    check("t8_data", q_data[0], 32'h103);
    check("t8_latency", q_cyc[0], acc + 2);

    // Flush on beat 3 with a new command in the same cycle
    q_data.delete(); q_cyc.delete();
    send(32'h0, 32'd32, a0, wr0);
    wait_cyc(a0 + 3);
    i_flush = 1'b1; bus.read = 1'b1; bus.addr = 32'h20; bus.burstcount = 32'd8;
    tick(1);
    i_flush = 1'b0; bus.read = 1'b0;
    wait_idle();
    check("t5_count", q_data.size(), 32'd4);
    check("t5_old0", q_data[0], 32'h100);
    check("t5_old1", q_data[1], 32'h101);
    check("t5_new0", q_data[2], 32'h108);
    check("t5_new1", q_data[3], 32'h109);
    check("t5_new_cyc", q_cyc[2], a0 + 6);

    // Loader write colliding with the burst read of the same word
    q_data.delete(); q_cyc.delete();
    send(32'h0, 32'd32, a0, wr0);
    wait_cyc(a0 + 6);
    i_ld_addr = 8'd5; i_ld_data = 32'hDEAD; i_ld_we = 1'b1;
    tick(1);
    i_ld_we = 1'b0;
    wait_idle();
    check("t6_count", q_data.size(), 32'd8);
    check("t6_old5", q_data[5], 32'h105);
    q_data.delete(); q_cyc.delete();
    send(32'h14, 32'd4, acc, wr0);
    wait_idle();
    check("t6_new5", q_data[0], 32'hDEAD);

    // Wrap around the top of the RAM
    ld(8'd254, 32'hAAAA0001);
    ld(8'd255, 32'hBBBB0002);
    ld(8'd0,   32'hCCCC0003);
    ld(8'd1,   32'hDDDD0004);
    q_data.delete(); q_cyc.delete();
    send(32'd254 * 4, 32'd16, acc, wr0);
    wait_idle();
    check("t4_count", q_data.size(), 32'd4);
    check("t4_a", q_data[0], 32'hAAAA0001);
    check("t4_b", q_data[1], 32'hBBBB0002);
    check("t4_c", q_data[2], 32'hCCCC0003);
    check("t4_d", q_data[3], 32'hDDDD0004);

    // Reset pulse mid-burst
    send(32'h0, 32'd32, a0, wr0);
    wait_cyc(a0 + 4);
    rst = 1'b0;
    #1;
    check("t7_valid", {31'd0, bus.readdatavalid}, 32'd0);
    check("t7_waitreq", {31'd0, bus.waitrequest}, 32'd1);
    check("t7_busy", {31'd0, o_busy}, 32'd0);
    tick(1);
    rst = 1'b1;
    #1;
    check("t7_rel_waitreq", {31'd0, bus.waitrequest}, 32'd0);
    check("t7_rel_busy", {31'd0, o_busy}, 32'd0);
    q_data.delete(); q_cyc.delete();
    tick(12);
    check("t7_no_beats", q_data.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/inst_mem_burst_responder.md
Name: inst_mem_burst_responder

Overview:
Avalon-MM-style burst read responder that serves the instruction fetch controller's read master: accepts (address, read, burstcount) commands under waitrequest and returns one instruction word per cycle on readdata/readdatavalid. Holds the instruction store in a synchronous single-port-read RAM plus a loader write port for program download. Queues commands in a small command FIFO so back-to-back fetches are accepted without bubbles. Supports a flush input, driven by the fetch controller's inst-fifo reset, that aborts all outstanding bursts on a jump/branch.

Parameters:
P_ADDR_BITS, 32, byte address width (matches MEM_ADDR_BITS)
P_WORD_BITS, 32, data word width (matches WORD_BITS); bytes per word = P_WORD_BITS>>3
P_DEPTH_LOG2, 8, log2 of RAM depth in words
P_CMD_DEPTH, 4, command FIFO entries (power of 2)
P_CMD_DEPTH_LOG2, 2, log2 of P_CMD_DEPTH

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
i_addr  in  P_ADDR_BITS  burst start byte address
i_read  in  1  read command valid
i_burstcount  in  P_WORD_BITS  burst length in BYTES
o_waitrequest  out  1  command not accepted this cycle
o_readdata  out  P_WORD_BITS  returned word
o_readdatavalid  out  1  o_readdata valid, one beat per assertion
i_flush  in  1  drop queued commands and the active burst
i_ld_addr  in  P_DEPTH_LOG2  loader word index
i_ld_data  in  P_WORD_BITS  loader write data
i_ld_we  in  1  loader write enable
o_busy  out  1  burst active or command FIFO non-empty

Behaviour:
- Reset (rst=0, async): command FIFO empty, state IDLE, beat counter 0, o_readdatavalid=0, o_readdata=0, o_busy=0, o_waitrequest=1. After release, o_waitrequest = command FIFO full. RAM contents are not reset.
- Command accept: in a cycle with i_read=1 and o_waitrequest=0, push {i_addr, i_burstcount} into the command FIFO. o_waitrequest is combinational from the FIFO-full flag only and does not depend on i_read.
- Beat count = i_burstcount >> log2(P_WORD_BITS/8). Low byte bits are ignored (floor). Start word index = i_addr >> log2(P_WORD_BITS/8); the low address bits are ignored.
- Zero-beat command: popped and discarded in one cycle with no data returned.
- FSM IDLE: if the FIFO is non-empty, pop the head, load r_word_idx and r_beats_left. Go to BURST if beats > 0, else stay in IDLE.
- FSM BURST: each cycle, issue a RAM read at r_word_idx, increment r_word_idx, decrement r_beats_left. On the last beat, if the FIFO is non-empty, pop the next command in the same cycle and stay in BURST (no bubble); otherwise go to IDLE.
- Word index wraps modulo 2^P_DEPTH_LOG2; address bits above the RAM range are ignored.
- Read latency: o_readdatavalid rises exactly 1 cycle after the RAM read is issued. First beat appears 2 cycles after the accept edge when idle (1 cycle pop/issue, 1 cycle RAM). Throughput is 1 beat/cycle with no backpressure.
- Accept and pop in the same cycle are legal. If the FIFO is full, a same-cycle pop does not lower o_waitrequest in that cycle.
- Flush (i_flush=1, synchronous):
  - Empties the FIFO and forces IDLE.
  - Suppresses o_readdatavalid in the following cycle, so a beat issued in the flush cycle is not returned.
  - A command presented in the flush cycle is accepted and survives; the flush clears the old entries and the new command is enqueued after the clear.
- Loader write: when i_ld_we=1, write RAM[i_ld_addr] on the clock edge. A read of the same index in the same cycle returns the OLD data (read-before-write). The loader write has priority and never stalls reads.
- o_busy = (state==BURST) | FIFO non-empty | (o_readdatavalid pending).
- Reset asserted mid-burst: all outputs go immediately to their reset values and the in-flight beat is lost.

Test Plan:
- Load RAM[0..7]=0x100..0x107. Then read addr=0x0, burstcount=32 -> o_readdatavalid high 8 consecutive cycles starting 2 cycles after accept, data 0x100..0x107, then o_busy=0.
- Two back-to-back commands (0x0 bc=16, 0x10 bc=16) with waitrequest low -> 8 contiguous beats 0x100..0x107, no gap between bursts.
- Fill FIFO with P_CMD_DEPTH=4 commands while a burst is active -> o_waitrequest=1 on the 5th attempt. The command is accepted the cycle after the first pop.
- addr=(2^8-2)*4, bc=16 with RAM[254,255,0,1]=A,B,C,D -> returns A,B,C,D (wrap-around).
- Mid-burst: assert i_flush in beat 3 of 8 while simultaneously presenting a new read 0x20 bc=8 -> at most 3 old beats seen, then exactly RAM[8],RAM[9], no old beats after that.
- Loader write RAM[5]=0xDEAD in the same cycle the burst reads index 5 -> beat returns the old value. A later re-read returns 0xDEAD.
- Drop rst low mid-burst for 1 cycle -> o_readdatavalid=0 and o_waitrequest=1 immediately. After release, o_waitrequest=0 and o_busy=0.
- Command with bc=0 -> no readdatavalid, FIFO drains, and the following command's latency is unaffected.
